// File: rtl/wb_stage_hs.sv
// Handshaked MIPS write-back stage: holds one instruction from MEM, waits for late load data,
// aligns sub-word and unaligned loads, commits to the register file and drives ID bypass/hazard info.
module wb_stage_hs #(
  parameter int PC_W    = 32,
  parameter int RADDR_W = 5,
  parameter int DATA_W  = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mem_valid,
  output logic               wb_allowin,
  input  logic [PC_W-1:0]    mem_pc,
  input  logic [RADDR_W-1:0] mem_waddr,
  input  logic [3:0]         mem_regwrite,
  input  logic               mem_is_load,
  input  logic [2:0]         mem_ld_type,
  input  logic [1:0]         mem_vaddr_lo,
  input  logic [DATA_W-1:0]  mem_rt_data,
  input  logic [DATA_W-1:0]  mem_result,
  input  logic               flush,
  input  logic               dresp_valid,
  input  logic [DATA_W-1:0]  dresp_data,
  output logic [3:0]         rf_we,
  output logic [RADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0]  rf_wdata,
  output logic [PC_W-1:0]    wb_pc,
  output logic               fwd_valid,
  output logic [RADDR_W-1:0] fwd_waddr,
  output logic [DATA_W-1:0]  fwd_data,
  output logic               ld_pending
);

  if (DATA_W != 32) begin : g_bad_width
    $error("wb_stage_hs: byte-lane logic supports DATA_W == 32 only");
  end

  localparam logic [2:0] LD_LW  = 3'd0;
  localparam logic [2:0] LD_LB  = 3'd1;
  localparam logic [2:0] LD_LBU = 3'd2;
  localparam logic [2:0] LD_LH  = 3'd3;
  localparam logic [2:0] LD_LHU = 3'd4;
  localparam logic [2:0] LD_LWL = 3'd5;
  localparam logic [2:0] LD_LWR = 3'd6;

  typedef enum logic [1:0] {S_EMPTY, S_HOLD, S_WAIT, S_DRAIN} state_t;

  state_t              state_q, state_d;
  logic [PC_W-1:0]     pc_q;
  logic [RADDR_W-1:0]  waddr_q;
  logic [3:0]          mask_q;
  logic [2:0]          ld_type_q;
  logic [1:0]          vaddr_q;
  logic [DATA_W-1:0]   rt_q;
  logic [DATA_W-1:0]   result_q;

  logic                allow_raw;
  logic                take;
  logic                commit;
  logic                fwd_live;
  logic [DATA_W-1:0]   wdata_calc;
  state_t              entry_state;

  // Odd halfword addresses never reach here (MEM raises AdEL), so only v[1] picks the half.
  function automatic logic [31:0] load_align(input logic [2:0] t, input logic [1:0] v,
                                             input logic [31:0] m, input logic [31:0] r);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    case (v)
      2'd0:    b = m[7:0];
      2'd1:    b = m[15:8];
      2'd2:    b = m[23:16];
      default: b = m[31:24];
    endcase
    h = v[1] ? m[31:16] : m[15:0];
    case (t)
      LD_LB:  res = {{24{b[7]}}, b};
      LD_LBU: res = {24'd0, b};
      LD_LH:  res = {{16{h[15]}}, h};
      LD_LHU: res = {16'd0, h};
      LD_LWL: begin
        case (v)
          2'd0:    res = {m[7:0],  r[23:0]};
          2'd1:    res = {m[15:0], r[15:0]};
          2'd2:    res = {m[23:0], r[7:0]};
          default: res = m;
        endcase
      end
      LD_LWR: begin
        case (v)
          2'd0:    res = m;
          2'd1:    res = {r[31:24], m[31:8]};
          2'd2:    res = {r[31:16], m[31:16]};
          default: res = {r[31:8],  m[31:24]};
        endcase
      end
      default: res = m;
    endcase
    return res;
  endfunction

  always_comb begin
    state_d     = state_q;
    allow_raw   = 1'b0;
    commit      = 1'b0;
    fwd_live    = 1'b0;
    entry_state = mem_is_load ? S_WAIT : S_HOLD;
    take        = 1'b0;
    case (state_q)
      S_EMPTY, S_HOLD: begin
        allow_raw = ~flush;
        commit    = (state_q == S_HOLD) & ~flush;
        fwd_live  = (state_q == S_HOLD);
        take      = mem_valid & allow_raw;
        if (flush)     state_d = S_EMPTY;
        else if (take) state_d = entry_state;
        else           state_d = S_EMPTY;
      end
      S_WAIT: begin
        allow_raw = dresp_valid & ~flush;
        commit    = dresp_valid & ~flush;
        fwd_live  = dresp_valid;
        take      = mem_valid & allow_raw;
        // A flushed load that has not seen its response must still absorb it.
        if (flush)            state_d = dresp_valid ? S_EMPTY : S_DRAIN;
        else if (dresp_valid) state_d = take ? entry_state : S_EMPTY;
        else                  state_d = S_WAIT;
      end
      S_DRAIN: begin
        if (dresp_valid) state_d = S_EMPTY;
      end
      default: state_d = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_EMPTY;
      pc_q      <= '0;
      waddr_q   <= '0;
      mask_q    <= '0;
      ld_type_q <= '0;
      vaddr_q   <= '0;
      rt_q      <= '0;
      result_q  <= '0;
    end else begin
      state_q <= state_d;
      if (take) begin
        pc_q      <= mem_pc;
        waddr_q   <= mem_waddr;
        mask_q    <= mem_regwrite;
        ld_type_q <= mem_ld_type;
        vaddr_q   <= mem_vaddr_lo;
        rt_q      <= mem_rt_data;
        result_q  <= mem_result;
      end
    end
  end

  always_comb begin
    wdata_calc = (state_q == S_HOLD) ? result_q
                                     : load_align(ld_type_q, vaddr_q, dresp_data, rt_q);
    wb_allowin = allow_raw & ~rst;
    rf_we      = (commit && waddr_q != '0) ? mask_q : 4'd0;
    rf_waddr   = commit ? waddr_q : '0;
    rf_wdata   = commit ? wdata_calc : '0;
    wb_pc      = commit ? pc_q : '0;
    fwd_valid  = fwd_live && (waddr_q != '0) && (mask_q != 4'd0);
    fwd_waddr  = waddr_q;
    fwd_data   = fwd_valid ? wdata_calc : '0;
    ld_pending = (state_q == S_WAIT);
  end

endmodule

// File: tb/tb_wb_stage_hs.sv
// Directed bench for wb_stage_hs: a slot-level reference model is compared every cycle,
// with hand-computed literals pinning the key scenarios.
module tb_wb_stage_hs;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid;
  logic        wb_allowin;
  logic [31:0] mem_pc;
  logic [4:0]  mem_waddr;
  logic [3:0]  mem_regwrite;
  logic        mem_is_load;
  logic [2:0]  mem_ld_type;
  logic [1:0]  mem_vaddr_lo;
  logic [31:0] mem_rt_data;
  logic [31:0] mem_result;
  logic        flush;
  logic        dresp_valid;
  logic [31:0] dresp_data;
  logic [3:0]  rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] wb_pc;
  logic        fwd_valid;
  logic [4:0]  fwd_waddr;
  logic [31:0] fwd_data;
  logic        ld_pending;

  int total = 0;
  int bad   = 0;

  // Model: the slot is empty (0), holds a ready result (1), awaits load data (2) or owes a drop (3).
  int          ph;
  logic [31:0] h_pc, h_res, h_rt;
  logic [4:0]  h_wa;
  logic [3:0]  h_mask;
  logic [2:0]  h_t;
  logic [1:0]  h_v;

  always #5 clk = ~clk;

  wb_stage_hs #(.PC_W(32), .RADDR_W(5), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .mem_valid(mem_valid), .wb_allowin(wb_allowin), .mem_pc(mem_pc),
    .mem_waddr(mem_waddr), .mem_regwrite(mem_regwrite), .mem_is_load(mem_is_load),
    .mem_ld_type(mem_ld_type), .mem_vaddr_lo(mem_vaddr_lo), .mem_rt_data(mem_rt_data),
    .mem_result(mem_result), .flush(flush), .dresp_valid(dresp_valid), .dresp_data(dresp_data),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .wb_pc(wb_pc),
    .fwd_valid(fwd_valid), .fwd_waddr(fwd_waddr), .fwd_data(fwd_data), .ld_pending(ld_pending)
  );

  function automatic logic [31:0] ref_align(input logic [2:0] t, input logic [1:0] v,
                                            input logic [31:0] m, input logic [31:0] r);
    logic [63:0] one;
    logic [31:0] sh, x;
    one = 64'd1;
    sh  = 32'(v) * 8;
    case (t)
      3'd1: begin x = (m >> sh) & 32'hFF;   if (x[7])  x = x | 32'hFFFF_FF00; end
      3'd2:       x = (m >> sh) & 32'hFF;
      3'd3: begin x = (m >> sh) & 32'hFFFF; if (x[15]) x = x | 32'hFFFF_0000; end
      3'd4:       x = (m >> sh) & 32'hFFFF;
      3'd5: begin
        sh = 32'(3 - int'(v)) * 8;
        x  = (m << sh) | (r & 32'((one << sh) - 64'd1));
      end
      3'd6:       x = (m >> sh) | (r & ~(32'hFFFF_FFFF >> sh));
      default:    x = m;
    endcase
    return x;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    ph = 0; h_pc = 0; h_res = 0; h_rt = 0; h_wa = 0; h_mask = 0; h_t = 0; h_v = 0;
  endtask

  function automatic logic model_allow();
    if (ph <= 1)  return !flush;
    if (ph == 2)  return dresp_valid && !flush;
    return 1'b0;
  endfunction

  task automatic model_compare();
    logic        live, com, fv;
    logic [31:0] val;
    if (dresp_valid && ph <= 1) begin
      total++; bad++;
      $display("FAIL protocol dresp_valid while no load outstanding t=%0t", $time);
    end
    live = (ph == 1) || (ph == 2 && dresp_valid);
    com  = live && !flush && !rst;
    val  = (ph == 1) ? h_res : ref_align(h_t, h_v, dresp_data, h_rt);
    fv   = live && h_wa != 0 && h_mask != 0;
    chk("allowin",    32'(wb_allowin), 32'(!rst && model_allow()));
    chk("rf_we",      32'(rf_we),      (com && h_wa != 0) ? 32'(h_mask) : 32'd0);
    chk("rf_waddr",   32'(rf_waddr),   com ? 32'(h_wa) : 32'd0);
    chk("rf_wdata",   rf_wdata,        com ? val : 32'd0);
    chk("wb_pc",      wb_pc,           com ? h_pc : 32'd0);
    chk("fwd_valid",  32'(fwd_valid),  32'(fv));
    chk("fwd_waddr",  32'(fwd_waddr),  32'(h_wa));
    chk("fwd_data",   fwd_data,        fv ? val : 32'd0);
    chk("ld_pending", 32'(ld_pending), 32'(ph == 2));
  endtask

  task automatic model_update();
    logic take;
    if (rst) begin
      model_reset();
    end else begin
      take = mem_valid && model_allow();
      if (ph <= 1)      ph = flush ? 0 : (take ? (mem_is_load ? 2 : 1) : 0);
      else if (ph == 2) begin
        if (flush)            ph = dresp_valid ? 0 : 3;
        else if (dresp_valid) ph = take ? (mem_is_load ? 2 : 1) : 0;
      end else if (dresp_valid) ph = 0;
      if (take) begin
        h_pc = mem_pc; h_res = mem_result; h_rt = mem_rt_data; h_wa = mem_waddr;
        h_mask = mem_regwrite; h_t = mem_ld_type; h_v = mem_vaddr_lo;
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    model_compare();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle();
    mem_valid = 0; flush = 0; dresp_valid = 0; dresp_data = 32'h0;
  endtask

  task automatic put(input logic ld, input logic [2:0] t, input logic [1:0] v, input logic [4:0] wa,
                     input logic [3:0] mk, input logic [31:0] res, input logic [31:0] rt,
                     input logic [31:0] pc);
    mem_valid = 1; mem_is_load = ld; mem_ld_type = t; mem_vaddr_lo = v; mem_waddr = wa;
    mem_regwrite = mk; mem_result = res; mem_rt_data = rt; mem_pc = pc;
  endtask

  task automatic resp(input logic [31:0] d);
    dresp_valid = 1; dresp_data = d;
  endtask

  logic [2:0]  lt_t [10];
  logic [1:0]  lt_v [10];
  logic [31:0] lt_m [10];
  logic [31:0] lt_e [10];

  initial begin
    lt_t[0] = 3'd2; lt_v[0] = 2'd1; lt_m[0] = 32'h1234_F678; lt_e[0] = 32'h0000_00F6;
    lt_t[1] = 3'd1; lt_v[1] = 2'd1; lt_m[1] = 32'h1234_F678; lt_e[1] = 32'hFFFF_FFF6;
    lt_t[2] = 3'd3; lt_v[2] = 2'd2; lt_m[2] = 32'h8001_0000; lt_e[2] = 32'hFFFF_8001;
    lt_t[3] = 3'd4; lt_v[3] = 2'd2; lt_m[3] = 32'h8001_0000; lt_e[3] = 32'h0000_8001;
    lt_t[4] = 3'd3; lt_v[4] = 2'd0; lt_m[4] = 32'h0000_7FFF; lt_e[4] = 32'h0000_7FFF;
    lt_t[5] = 3'd0; lt_v[5] = 2'd0; lt_m[5] = 32'hCAFE_BABE; lt_e[5] = 32'hCAFE_BABE;
    lt_t[6] = 3'd5; lt_v[6] = 2'd3; lt_m[6] = 32'h1122_3344; lt_e[6] = 32'h1122_3344;
    lt_t[7] = 3'd6; lt_v[7] = 2'd0; lt_m[7] = 32'h1122_3344; lt_e[7] = 32'h1122_3344;
    lt_t[8] = 3'd5; lt_v[8] = 2'd0; lt_m[8] = 32'h1122_3344; lt_e[8] = 32'h44BB_CCDD;
    lt_t[9] = 3'd6; lt_v[9] = 2'd3; lt_m[9] = 32'h1122_3344; lt_e[9] = 32'hAABB_CC11;

    rst = 1; idle();
    put(0, 3'd0, 2'd0, 5'd0, 4'h0, 32'h0, 32'h0, 32'h0); mem_valid = 0;
    model_reset();
    #1;
    step();
    chk("rst_allowin", 32'(wb_allowin), 32'd0);
    chk("rst_rf_we",   32'(rf_we),      32'd0);
    step();
    rst = 0; #1;
    chk("post_rst_allowin", 32'(wb_allowin), 32'd1);

    // ALU op commits one cycle after transfer
    put(0, 3'd0, 2'd0, 5'd8, 4'hF, 32'h1234_5678, 32'h0, 32'h100); step();
    idle(); #1;
    chk("alu_we",    32'(rf_we),     32'hF);
    chk("alu_waddr", 32'(rf_waddr),  32'd8);
    chk("alu_wdata", rf_wdata,       32'h1234_5678);
    chk("alu_fwd",   32'(fwd_valid), 32'd1);
    chk("alu_pc",    wb_pc,          32'h100);
    step();

    // LB v=3 with a response three cycles late
    put(1, 3'd1, 2'd3, 5'd9, 4'hF, 32'h0, 32'h0, 32'h104); step();
    idle();
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("lb_pending", 32'(ld_pending), 32'd1);
      chk("lb_allowin", 32'(wb_allowin), 32'd0);
      step();
    end
    resp(32'h80AA_BBCC); #1;
    chk("lb_wdata",   rf_wdata,        32'hFFFF_FF80);
    chk("lb_allowin", 32'(wb_allowin), 32'd1);
    step();

    // LWL then LWR back to back on the same response word
    idle(); put(1, 3'd5, 2'd1, 5'd10, 4'hF, 32'h0, 32'hAABB_CCDD, 32'h108); step();
    put(1, 3'd6, 2'd2, 5'd11, 4'hF, 32'h0, 32'hAABB_CCDD, 32'h10C); resp(32'h1122_3344); #1;
    chk("lwl_wdata", rf_wdata,       32'h3344_CCDD);
    chk("lwl_waddr", 32'(rf_waddr),  32'd10);
    step();
    mem_valid = 0; resp(32'h1122_3344); #1;
    chk("lwr_wdata", rf_wdata, 32'hAABB_1122);
    step();

    // Sub-word alignment table
    for (int k = 0; k < 10; k++) begin
      idle(); put(1, lt_t[k], lt_v[k], 5'd3, 4'hF, 32'h0, 32'hAABB_CCDD, 32'h200 + 32'(k)); step();
      mem_valid = 0; resp(lt_m[k]); #1;
      chk("align_wdata", rf_wdata, lt_e[k]);
      step();
    end

    // Load to $0: no write, no bypass
    idle(); put(1, 3'd0, 2'd0, 5'd0, 4'hF, 32'h0, 32'h0, 32'h300); step();
    mem_valid = 0; resp(32'hDEAD_BEEF); #1;
    chk("r0_we",  32'(rf_we),     32'd0);
    chk("r0_fwd", 32'(fwd_valid), 32'd0);
    step();
    idle(); #1;
    chk("r0_pending", 32'(ld_pending), 32'd0);
    chk("r0_allowin", 32'(wb_allowin), 32'd1);
    step();

    // Flush in WAIT, response two cycles later is drained; MEM keeps an ALU op waiting
    put(1, 3'd0, 2'd0, 5'd12, 4'hF, 32'h0, 32'h0, 32'h400); step();
    put(0, 3'd0, 2'd0, 5'd13, 4'hF, 32'h0000_0D0D, 32'h0, 32'h404); flush = 1; #1;
    chk("fl_allowin", 32'(wb_allowin), 32'd0);
    step();
    #1;
    chk("drain_allowin", 32'(wb_allowin), 32'd0);
    chk("drain_pending", 32'(ld_pending), 32'd0);
    step();
    flush = 0; resp(32'h0000_0055); #1;
    chk("drain_we",      32'(rf_we),      32'd0);
    chk("drain_allowin", 32'(wb_allowin), 32'd0);
    step();
    dresp_valid = 0; #1;
    chk("after_drain_allowin", 32'(wb_allowin), 32'd1);
    step();
    idle(); #1;
    chk("held_alu_waddr", 32'(rf_waddr), 32'd13);
    chk("held_alu_we",    32'(rf_we),    32'hF);
    step();

    // Flush in HOLD suppresses the commit
    put(0, 3'd0, 2'd0, 5'd14, 4'hF, 32'h0000_0E0E, 32'h0, 32'h500); step();
    idle(); flush = 1; #1;
    chk("flush_hold_we", 32'(rf_we), 32'd0);
    step();

    // Flush in WAIT coinciding with the response discards it
    idle(); put(1, 3'd0, 2'd0, 5'd15, 4'hF, 32'h0, 32'h0, 32'h504); step();
    mem_valid = 0; flush = 1; resp(32'h0000_0F0F); #1;
    chk("flush_resp_we", 32'(rf_we), 32'd0);
    step();
    idle(); #1;
    chk("flush_resp_pending", 32'(ld_pending), 32'd0);
    chk("flush_resp_allowin", 32'(wb_allowin), 32'd1);
    step();

    // Back-to-back ALU ops
    for (int i = 0; i < 6; i++) begin
      put(0, 3'd0, 2'd0, 5'(i + 1), 4'hF, 32'h1111_1111 * 32'(i + 1), 32'h0, 32'h600 + 32'(4 * i));
      #1;
      chk("b2b_allowin", 32'(wb_allowin), 32'd1);
      if (i > 0) begin
        chk("b2b_wdata", rf_wdata,      32'h1111_1111 * 32'(i));
        chk("b2b_waddr", 32'(rf_waddr), 32'(i));
      end
      step();
    end
    idle(); #1;
    chk("b2b_last", rf_wdata, 32'h6666_6666);
    step();

    // Asynchronous reset while a load waits
    put(1, 3'd0, 2'd0, 5'd20, 4'hF, 32'h0, 32'h0, 32'h700); step();
    idle(); #1;
    chk("arst_pre_pending", 32'(ld_pending), 32'd1);
    rst = 1; model_reset(); #1;
    chk("arst_pending", 32'(ld_pending), 32'd0);
    chk("arst_allowin", 32'(wb_allowin), 32'd0);
    chk("arst_fwd_wa",  32'(fwd_waddr),  32'd0);
    chk("arst_we",      32'(rf_we),      32'd0);
    step();
    rst = 0; #1;
    chk("arst_after_allowin", 32'(wb_allowin), 32'd1);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
